bit_serial_adder: RTL and testbench



---
 rtl/bit_serial_adder.sv | 115 +++++++++++
 tb/tb_bit_serial_adder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell, one bit per clock, LSB first; WIDTH-bit add in WIDTH cycles.
// Optional subtract mode (a + ~b + 1) is compiled in when SERIAL_SUB_EN is defined.
module bit_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, cout_q, sub_q;
   logic             ready_q, busy_q, done_q;

   logic             sub_eff;
   logic             fa_a, fa_b, fa_s, fa_c;
   logic [WIDTH-1:0] a_sr_d, b_sr_d, sum_d;
   logic [CW-1:0]    cnt_d;

`ifdef SERIAL_SUB_EN
   assign sub_eff = sub;
`else
   logic unused_sub;
   assign unused_sub = sub;
   assign sub_eff    = 1'b0;
`endif

   // The single full-adder cell; B is inverted for subtraction, the +1 comes from the preset carry.
   assign fa_a = a_sr_q[0];
   assign fa_b = b_sr_q[0] ^ sub_q;
   assign fa_s = fa_a ^ fa_b ^ carry_q;
   assign fa_c = (fa_a & fa_b) | (fa_a & carry_q) | (fa_b & carry_q);

   assign a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
   assign b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
   assign sum_d  = {fa_s, sum_q[WIDTH-1:1]};
   assign cnt_d  = cnt_q + CW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         sub_q   <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_sr_q  <= a;
                  b_sr_q  <= b;
                  carry_q <= sub_eff;
                  sub_q   <= sub_eff;
                  cnt_q   <= '0;
                  state_q <= RUN;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            RUN: begin
               carry_q <= fa_c;
               sum_q   <= sum_d;
               a_sr_q  <= a_sr_d;
               b_sr_q  <= b_sr_d;
               cnt_q   <= cnt_d;
               if (cnt_q == LAST_BIT) begin
                  cout_q  <= fa_c;
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ready = ready_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign sum   = sum_q;
   assign cout  = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder (WIDTH=8): stimulus pushes expected results, a monitor pops on done.
module tb_bit_serial_adder;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         sub = 1'b0;
   logic         ready, busy, done, cout;
   logic [W-1:0] sum;

   bit_serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sub(sub),
      .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      int           done_cyc;
      string        name;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   busy_cnt = 0;
   int   last_done_cyc = 0;
   int   prev_done_cyc = 0;
   logic prev_done = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: everything is sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         busy_cnt  = 0;
         prev_done = 1'b0;
      end else begin
         if (prev_done) begin
            chk("done_one_cycle", {31'b0, done}, 32'd0);
            chk("ready_after_done", {31'b0, ready}, 32'd1);
         end
         if (busy) busy_cnt++;
         else if (ready) busy_cnt = 0;
         if (done) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_done: got done with sum=%0h cout=%0b, required no done", sum, cout);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk({e.name, "_sum"}, {24'b0, sum}, {24'b0, e.sum});
               chk({e.name, "_cout"}, {31'b0, cout}, {31'b0, e.cout});
               chk({e.name, "_done_cycle"}, cyc, e.done_cyc);
               chk({e.name, "_busy_cycles"}, busy_cnt, W);
               chk({e.name, "_flags_in_done"}, {30'b0, ready, busy}, 32'd0);
               $display("op %s: sum=%0h cout=%0b at cycle %0d", e.name, sum, cout, cyc);
            end
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            busy_cnt      = 0;
         end
         prev_done = done;
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: ready=%0b after %0d cycles, required 1", ready, n);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: %0d results outstanding, required 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   // Issue one operation at a falling edge; the accepting edge is the next rising edge.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                        input logic [W-1:0] esum, input logic ecout, input string nm);
      exp_t e;
      wait_ready();
      start = 1'b1;
      a = ta;
      b = tb;
      sub = ts;
      e.sum = esum;
      e.cout = ecout;
      e.done_cyc = cyc + W + 1;
      e.name = nm;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      a = ~ta;
      b = ~tb;
      sub = ~ts;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_ready", {31'b0, ready}, 32'd1);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_done", {31'b0, done}, 32'd0);
      chk("reset_sum", {24'b0, sum}, 32'd0);
      chk("reset_cout", {31'b0, cout}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      do_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "add_5a_3c");
      drain();

      do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
      do_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "add_00_00_b2b");
      drain();
      chk("b2b_done_spacing", last_done_cyc - prev_done_cyc, W + 2);

      // Start while busy must be ignored.
      do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "add_12_34_ignored_start");
      @(negedge clk);
      @(negedge clk);
      chk("busy_during_run", {31'b0, busy}, 32'd1);
      start = 1'b1;
      a = 8'hFF;
      b = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (12) @(negedge clk);

      // Asynchronous reset between E4 and E5.
      wait_ready();
      start = 1'b1;
      a = 8'h80;
      b = 8'h80;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midop_reset_ready", {31'b0, ready}, 32'd1);
      chk("midop_reset_busy", {31'b0, busy}, 32'd0);
      chk("midop_reset_done", {31'b0, done}, 32'd0);
      chk("midop_reset_sum", {24'b0, sum}, 32'd0);
      chk("midop_reset_cout", {31'b0, cout}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      do_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "add_01_02_after_reset");
      drain();

      do_op(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, "add_a5_5a");
      do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "add_80_80");
      do_op(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, "add_ff_ff");
      drain();

`ifdef SERIAL_SUB_EN
      do_op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, "sub_10_01");
      do_op(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, "sub_01_02");
      do_op(8'h37, 8'h37, 1'b1, 8'h00, 1'b1, "sub_37_37");
`else
      do_op(8'h10, 8'h01, 1'b1, 8'h11, 1'b0, "sub_ignored_10_01");
      do_op(8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, "sub_ignored_ff_01");
`endif
      drain();
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
